// File: rtl/st7735_spi_receiver.sv
// Display-side ST7735 4-wire SPI receiver: synchronizes the serial link, assembles bytes
// and decodes CASET/RASET/RAMWR into addressed RGB565 pixel writes.
module st7735_spi_receiver #(
    parameter int ADDR_W = 7,
    parameter int X_MAX  = 127,
    parameter int Y_MAX  = 127
) (
    input  logic              clk_main,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_d_c,
    input  logic              spi_ss,
    output logic              byte_valid,
    output logic [7:0]        byte_data,
    output logic              byte_is_cmd,
    output logic              pixel_valid,
    output logic [ADDR_W-1:0] pixel_addr_x,
    output logic [ADDR_W-1:0] pixel_addr_y,
    output logic [15:0]       pixel_data,
    output logic              frame_done,
    output logic              ramwr_active
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_RASET,
        ST_RAMWR_HI,
        ST_RAMWR_LO,
        ST_IGNORE
    } state_t;

    localparam logic [7:0]        CMD_CASET = 8'h2A;
    localparam logic [7:0]        CMD_RASET = 8'h2B;
    localparam logic [7:0]        CMD_RAMWR = 8'h2C;
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W-1:0] X_END_RST = ADDR_W'(X_MAX);
    localparam logic [ADDR_W-1:0] Y_END_RST = ADDR_W'(Y_MAX);

    logic [1:0] sclk_sync, mosi_sync, dc_sync, ss_sync;
    logic       sclk_prev, ss_prev;
    logic       sclk_rise;
    logic [2:0] bit_cnt;
    logic [6:0] shift_reg;

    state_t              state, state_next;
    logic [1:0]          param_cnt;
    logic [7:0]          param_hi;
    logic [ADDR_W-1:0]   stage_start;
    logic [7:0]          pix_hi;
    logic [ADDR_W-1:0]   x_start, x_end, y_start, y_end;
    logic [ADDR_W-1:0]   cur_x, cur_y;
    logic                x_wrap, y_wrap;

    // A byte whose 8th edge coincides with SS rising still counts, so the previous SS level is accepted too.
    assign sclk_rise = sclk_sync[1] & ~sclk_prev & (~ss_sync[1] | ~ss_prev);
    assign x_wrap    = (cur_x == x_end) || (cur_x == ADDR_LAST);
    assign y_wrap    = (cur_y == y_end) || (cur_y == ADDR_LAST);
    assign ramwr_active = (state == ST_RAMWR_HI) || (state == ST_RAMWR_LO);

    // NOTE: every clocked process uses <= so all registers update from pre-edge values.
    always_ff @(posedge clk_main or posedge rst) begin
        if (rst) begin
            sclk_sync   <= 2'b00;
            mosi_sync   <= 2'b00;
            dc_sync     <= 2'b00;
            ss_sync     <= 2'b11;
            sclk_prev   <= 1'b0;
            ss_prev     <= 1'b1;
            bit_cnt     <= 3'd0;
            shift_reg   <= 7'd0;
            byte_valid  <= 1'b0;
            byte_data   <= 8'd0;
            byte_is_cmd <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[0], spi_clk};
            mosi_sync  <= {mosi_sync[0], spi_mosi};
            dc_sync    <= {dc_sync[0], spi_d_c};
            ss_sync    <= {ss_sync[0], spi_ss};
            sclk_prev  <= sclk_sync[1];
            ss_prev    <= ss_sync[1];
            byte_valid <= 1'b0;
            if (sclk_rise) begin
                if (bit_cnt == 3'd7) begin
                    byte_data   <= {shift_reg, mosi_sync[1]};
                    byte_is_cmd <= ~dc_sync[1];
                    byte_valid  <= 1'b1;
                    bit_cnt     <= 3'd0;
                end else begin
                    shift_reg <= {shift_reg[5:0], mosi_sync[1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                end
            end else if (ss_sync[1]) begin
                bit_cnt <= 3'd0;
            end
        end
    end

    always_ff @(posedge clk_main or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        if (byte_valid) begin
            if (byte_is_cmd) begin
                case (byte_data)
                    CMD_CASET: state_next = ST_CASET;
                    CMD_RASET: state_next = ST_RASET;
                    CMD_RAMWR: state_next = ST_RAMWR_HI;
                    default:   state_next = ST_IGNORE;
                endcase
            end else begin
                case (state)
                    ST_CASET, ST_RASET: if (param_cnt == 2'd3) state_next = ST_IDLE;
                    ST_RAMWR_HI:        state_next = ST_RAMWR_LO;
                    ST_RAMWR_LO:        state_next = ST_RAMWR_HI;
                    default:            state_next = state;
                endcase
            end
        end
    end

    always_ff @(posedge clk_main or posedge rst) begin
        if (rst) begin
            param_cnt    <= 2'd0;
            param_hi     <= 8'd0;
            stage_start  <= '0;
            pix_hi       <= 8'd0;
            x_start      <= '0;
            x_end        <= X_END_RST;
            y_start      <= '0;
            y_end        <= Y_END_RST;
            cur_x        <= '0;
            cur_y        <= '0;
            pixel_valid  <= 1'b0;
            pixel_addr_x <= '0;
            pixel_addr_y <= '0;
            pixel_data   <= 16'd0;
            frame_done   <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            if (byte_valid) begin
                if (byte_is_cmd) begin
                    param_cnt <= 2'd0;
                    if (byte_data == CMD_RAMWR) begin
                        cur_x <= x_start;
                        cur_y <= y_start;
                    end
                end else begin
                    case (state)
                        ST_CASET, ST_RASET: begin
                            param_cnt <= param_cnt + 2'd1;
                            case (param_cnt)
                                2'd0, 2'd2: param_hi    <= byte_data;
                                2'd1:       stage_start <= ADDR_W'({param_hi, byte_data});
                                default: begin
                                    // The window only changes once all four parameters have arrived.
                                    if (state == ST_CASET) begin
                                        x_start <= stage_start;
                                        x_end   <= ADDR_W'({param_hi, byte_data});
                                    end else begin
                                        y_start <= stage_start;
                                        y_end   <= ADDR_W'({param_hi, byte_data});
                                    end
                                end
                            endcase
                        end
                        ST_RAMWR_HI: pix_hi <= byte_data;
                        ST_RAMWR_LO: begin
                            pixel_valid  <= 1'b1;
                            pixel_addr_x <= cur_x;
                            pixel_addr_y <= cur_y;
                            pixel_data   <= {pix_hi, byte_data};
                            if (x_wrap) begin
                                cur_x <= x_start;
                                if (y_wrap) begin
                                    cur_y      <= y_start;
                                    frame_done <= 1'b1;
                                end else begin
                                    cur_y <= cur_y + ADDR_W'(1);
                                end
                            end else begin
                                cur_x <= cur_x + ADDR_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_st7735_spi_receiver.sv
// Scoreboard bench for st7735_spi_receiver: drives SPI bytes, queues expected bytes and
// pixels as stimulus is sent, and pops/compares them when the receiver reports them.
`timescale 1ns/1ps
module tb_st7735_spi_receiver;

    localparam int HALF = 3;

    typedef struct packed {
        logic [7:0] data;
        logic       is_cmd;
    } exp_byte_t;

    typedef struct packed {
        logic [6:0]  x;
        logic [6:0]  y;
        logic [15:0] data;
        logic        fd;
    } exp_pix_t;

    logic        clk_main = 1'b0;
    logic        rst = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_d_c = 1'b0;
    logic        spi_ss = 1'b1;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_is_cmd;
    logic        pixel_valid;
    logic [6:0]  pixel_addr_x;
    logic [6:0]  pixel_addr_y;
    logic [15:0] pixel_data;
    logic        frame_done;
    logic        ramwr_active;

    exp_byte_t exp_bytes[$];
    exp_pix_t  exp_pix[$];
    int total = 0;
    int bad = 0;
    int pix_count = 0;
    int fd_count = 0;
    int last_lat = 0;
    bit ss_toggle = 1'b0;

    st7735_spi_receiver dut (
        .clk_main    (clk_main),
        .rst         (rst),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_d_c     (spi_d_c),
        .spi_ss      (spi_ss),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_is_cmd (byte_is_cmd),
        .pixel_valid (pixel_valid),
        .pixel_addr_x(pixel_addr_x),
        .pixel_addr_y(pixel_addr_y),
        .pixel_data  (pixel_data),
        .frame_done  (frame_done),
        .ramwr_active(ramwr_active)
    );

    always #5 clk_main = ~clk_main;

    // Scoreboard: pop the oldest expectation whenever the receiver reports a byte or pixel.
    always @(negedge clk_main) begin
        exp_byte_t eb;
        exp_pix_t  ep;
        if (byte_valid) begin
            total++;
            if (exp_bytes.size() == 0) begin
                bad++;
                $display("FAIL byte_unexpected: got data=%h cmd=%b, none expected", byte_data, byte_is_cmd);
            end else begin
                eb = exp_bytes.pop_front();
                if (byte_data !== eb.data || byte_is_cmd !== eb.is_cmd) begin
                    bad++;
                    $display("FAIL byte: got data=%h cmd=%b, want data=%h cmd=%b",
                             byte_data, byte_is_cmd, eb.data, eb.is_cmd);
                end
            end
        end
        if (pixel_valid) begin
            pix_count++;
            if (frame_done) fd_count++;
            total++;
            if (exp_pix.size() == 0) begin
                bad++;
                $display("FAIL pixel_unexpected: got (%0d,%0d) %h fd=%b, none expected",
                         pixel_addr_x, pixel_addr_y, pixel_data, frame_done);
            end else begin
                ep = exp_pix.pop_front();
                if (pixel_addr_x !== ep.x || pixel_addr_y !== ep.y ||
                    pixel_data !== ep.data || frame_done !== ep.fd) begin
                    bad++;
                    $display("FAIL pixel: got (%0d,%0d) %h fd=%b, want (%0d,%0d) %h fd=%b",
                             pixel_addr_x, pixel_addr_y, pixel_data, frame_done,
                             ep.x, ep.y, ep.data, ep.fd);
                end
            end
        end else if (frame_done) begin
            total++;
            bad++;
            $display("FAIL frame_done_alone: got frame_done=1 without pixel_valid, want 0");
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_main);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic is_data);
        exp_bytes.push_back(exp_byte_t'{b, ~is_data});
        if (ss_toggle) begin
            spi_ss = 1'b0;
            tick(2);
        end
        for (int i = 7; i >= 0; i--) begin
            spi_clk  = 1'b0;
            spi_mosi = b[i];
            spi_d_c  = is_data;
            tick(HALF);
            spi_clk = 1'b1;
            if (i != 0) begin
                tick(HALF);
            end else begin
                last_lat = 0;
                for (int k = 1; k <= 6; k++) begin
                    @(posedge clk_main);
                    @(negedge clk_main);
                    if (byte_valid && last_lat == 0) last_lat = k;
                end
                tick(1);
            end
        end
        spi_clk = 1'b0;
        tick(HALF);
        if (ss_toggle) begin
            spi_ss = 1'b1;
            tick(3);
        end
    endtask

    task automatic cmd(input logic [7:0] b);
        send_byte(b, 1'b0);
    endtask

    task automatic dat(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    task automatic send_pixel(input logic [15:0] d, input int ex, input int ey, input logic efd);
        exp_pix.push_back(exp_pix_t'{7'(ex), 7'(ey), d, efd});
        dat(d[15:8]);
        dat(d[7:0]);
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        spi_d_c  = 1'b0;
        spi_ss   = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(3);
        exp_bytes.delete();
        exp_pix.delete();
        pix_count = 0;
        fd_count  = 0;
    endtask

    task automatic settle(input string name);
        tick(20);
        total++;
        if (exp_bytes.size() != 0 || exp_pix.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d bytes %0d pixels outstanding, want 0 0",
                     name, exp_bytes.size(), exp_pix.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        total++;
        if ({byte_valid, byte_data, byte_is_cmd, pixel_valid, pixel_addr_x, pixel_addr_y,
             pixel_data, frame_done, ramwr_active} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got bv=%b bd=%h cmd=%b pv=%b x=%0d y=%0d pd=%h fd=%b ra=%b, want all 0",
                     byte_valid, byte_data, byte_is_cmd, pixel_valid, pixel_addr_x,
                     pixel_addr_y, pixel_data, frame_done, ramwr_active);
        end
        apply_reset();
        spi_ss = 1'b0;
        tick(2);
        cmd(8'h2C);
        total++;
        if (last_lat !== 3) begin
            bad++;
            $display("FAIL byte_latency: got %0d cycles, want 3", last_lat);
        end
        send_pixel(16'hF800, 0, 0, 1'b0);
        settle("reset_pixel");
        total++;
        if (pix_count !== 1) begin
            bad++;
            $display("FAIL reset_pixel_count: got %0d, want 1", pix_count);
        end
    endtask

    task automatic test_window();
        cmd(8'h2A); dat(8'h00); dat(8'h10); dat(8'h00); dat(8'h11);
        cmd(8'h2B); dat(8'h00); dat(8'h20); dat(8'h00); dat(8'h21);
        cmd(8'h2C);
        total++;
        if (ramwr_active !== 1'b1) begin
            bad++;
            $display("FAIL window_ramwr_active: got %b, want 1", ramwr_active);
        end
        send_pixel(16'h1111, 16, 32, 1'b0);
        send_pixel(16'h2222, 17, 32, 1'b0);
        send_pixel(16'h3333, 16, 33, 1'b0);
        send_pixel(16'h4444, 17, 33, 1'b1);
        send_pixel(16'h5555, 16, 32, 1'b0);
        settle("window");
        total++;
        if (fd_count !== 1) begin
            bad++;
            $display("FAIL window_frame_done_count: got %0d, want 1", fd_count);
        end
    endtask

    task automatic test_abort();
        apply_reset();
        spi_ss = 1'b0;
        tick(2);
        cmd(8'h2A); dat(8'h00); dat(8'h05);
        cmd(8'h2C);
        send_pixel(16'h1357, 0, 0, 1'b0);
        dat(8'hEE);
        cmd(8'h2C);
        send_pixel(16'h2468, 0, 0, 1'b0);
        send_pixel(16'h9ABC, 1, 0, 1'b0);
        cmd(8'h11);
        total++;
        if (ramwr_active !== 1'b0) begin
            bad++;
            $display("FAIL ignore_ramwr_active: got %b, want 0", ramwr_active);
        end
        dat(8'hAA);
        dat(8'hBB);
        settle("abort");
        total++;
        if (pix_count !== 3) begin
            bad++;
            $display("FAIL abort_pixel_count: got %0d, want 3", pix_count);
        end
    endtask

    task automatic test_addr_limits();
        apply_reset();
        spi_ss = 1'b0;
        tick(2);
        cmd(8'h2A); dat(8'h00); dat(8'h7E); dat(8'h00); dat(8'h02);
        cmd(8'h2B); dat(8'h00); dat(8'h7F); dat(8'h00); dat(8'h01);
        cmd(8'h2C);
        send_pixel(16'hA001, 126, 127, 1'b0);
        send_pixel(16'hA002, 127, 127, 1'b1);
        send_pixel(16'hA003, 126, 127, 1'b0);
        cmd(8'h2A); dat(8'h01); dat(8'h05); dat(8'h01); dat(8'h06);
        cmd(8'h2B); dat(8'h01); dat(8'h00); dat(8'h01); dat(8'h00);
        cmd(8'h2C);
        send_pixel(16'hB001, 5, 0, 1'b0);
        send_pixel(16'hB002, 6, 0, 1'b1);
        send_pixel(16'hB003, 5, 0, 1'b0);
        settle("addr_limits");
    endtask

    task automatic test_partial_byte();
        apply_reset();
        spi_ss = 1'b0;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            spi_clk  = 1'b0;
            spi_mosi = i[0];
            spi_d_c  = 1'b1;
            tick(HALF);
            spi_clk = 1'b1;
            tick(HALF);
        end
        spi_clk = 1'b0;
        tick(HALF);
        spi_ss = 1'b1;
        tick(4);
        spi_ss = 1'b0;
        tick(2);
        cmd(8'h2C);
        settle("partial_byte");
        total++;
        if (ramwr_active !== 1'b1) begin
            bad++;
            $display("FAIL partial_ramwr_active: got %b, want 1", ramwr_active);
        end
    endtask

    task automatic test_ss_same_edge();
        logic [7:0] b;
        apply_reset();
        b = 8'hA5;
        exp_bytes.push_back(exp_byte_t'{b, 1'b0});
        spi_ss = 1'b0;
        tick(2);
        for (int i = 7; i >= 0; i--) begin
            spi_clk  = 1'b0;
            spi_mosi = b[i];
            spi_d_c  = 1'b1;
            tick(HALF);
            spi_clk = 1'b1;
            if (i == 0) spi_ss = 1'b1;
            tick(HALF);
        end
        tick(4);
        spi_clk = 1'b0;
        tick(HALF);
        spi_ss = 1'b0;
        tick(2);
        cmd(8'h2C);
        send_pixel(16'h0F0F, 0, 0, 1'b0);
        settle("ss_same_edge");
    endtask

    task automatic test_full_frame();
        apply_reset();
        ss_toggle = 1'b1;
        cmd(8'h2A); dat(8'h00); dat(8'h70); dat(8'h00); dat(8'h7F);
        cmd(8'h2B); dat(8'h00); dat(8'h78); dat(8'h00); dat(8'h7F);
        cmd(8'h2C);
        for (int y = 120; y <= 127; y++) begin
            for (int x = 112; x <= 127; x++) begin
                send_pixel({1'b0, 7'(y), 1'b0, 7'(x)}, x, y, (x == 127 && y == 127));
            end
        end
        send_pixel(16'hFFFF, 112, 120, 1'b0);
        ss_toggle = 1'b0;
        settle("full_frame");
        total++;
        if (pix_count !== 129) begin
            bad++;
            $display("FAIL frame_pixel_count: got %0d, want 129", pix_count);
        end
        total++;
        if (fd_count !== 1) begin
            bad++;
            $display("FAIL frame_done_count: got %0d, want 1", fd_count);
        end
    endtask

    task automatic test_reset_mid_pixel();
        apply_reset();
        spi_ss = 1'b0;
        tick(2);
        cmd(8'h2C);
        dat(8'h12);
        rst = 1'b1;
        tick(2);
        total++;
        if ({byte_valid, byte_data, byte_is_cmd, pixel_valid, pixel_addr_x, pixel_addr_y,
             pixel_data, frame_done, ramwr_active} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: got bd=%h pv=%b pd=%h ra=%b, want all 0",
                     byte_data, pixel_valid, pixel_data, ramwr_active);
        end
        rst = 1'b0;
        tick(3);
        dat(8'h34);
        dat(8'h56);
        tick(10);
        total++;
        if (pix_count !== 0) begin
            bad++;
            $display("FAIL midreset_no_pixel: got %0d pixels, want 0", pix_count);
        end
        cmd(8'h2C);
        send_pixel(16'hABCD, 0, 0, 1'b0);
        settle("midreset");
    endtask

    initial begin
        test_reset();
        test_window();
        test_abort();
        test_addr_limits();
        test_partial_byte();
        test_ss_same_edge();
        test_full_frame();
        test_reset_mid_pixel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
